// File: rtl/clap_sequence_decoder.sv
// Groups clap strobes into sequences and emits one command per sequence with the clap count.
// Optional post-command lockout is compiled in with `define CLAP_COOLDOWN_EN.
module clap_sequence_decoder #(
  parameter int unsigned GAP_TIMEOUT     = 50_000_000,
  parameter int unsigned MAX_CLAPS       = 4,
  parameter int unsigned COOLDOWN_CYCLES = 20_000_000
) (
  input  logic                           M_CLK,
  input  logic                           rst_i,
  input  logic                           clap_pulse_i,
  input  logic                           enable_i,
  output logic                           cmd_valid_o,
  output logic [$clog2(MAX_CLAPS+1)-1:0] cmd_count_o,
  output logic                           toggle_o,
  output logic                           busy_o
);

  localparam int unsigned CW     = $clog2(MAX_CLAPS + 1);
  localparam int unsigned TW_GAP = $clog2(GAP_TIMEOUT + 1);
`ifdef CLAP_COOLDOWN_EN
  localparam int unsigned TW_CD  = $clog2(COOLDOWN_CYCLES + 1);
  localparam int unsigned TW     = (TW_CD > TW_GAP) ? TW_CD : TW_GAP;
`else
  localparam int unsigned TW     = TW_GAP;
`endif

  if (GAP_TIMEOUT < 2) begin : g_bad_gap
    $error("GAP_TIMEOUT must be >= 2");
  end
  if (MAX_CLAPS < 2) begin : g_bad_max
    $error("MAX_CLAPS must be >= 2");
  end
  if (COOLDOWN_CYCLES < 1) begin : g_bad_cooldown
    $error("COOLDOWN_CYCLES must be >= 1");
  end

`ifdef CLAP_COOLDOWN_EN
  typedef enum logic [1:0] {IDLE, COUNTING, COOLDOWN} state_t;
`else
  typedef enum logic [1:0] {IDLE, COUNTING} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;

  assign busy_o = (state != IDLE);

  always_ff @(posedge M_CLK) begin
    if (rst_i) begin
      state       <= IDLE;
      count       <= '0;
      timer       <= '0;
      cmd_valid_o <= 1'b0;
      cmd_count_o <= '0;
      toggle_o    <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (clap_pulse_i && enable_i) begin
            state <= COUNTING;
            count <= CW'(1);
            timer <= '0;
          end
        end
        COUNTING: begin
          if (!enable_i) begin
            state <= IDLE;
            count <= '0;
            timer <= '0;
          end else if (clap_pulse_i) begin
            // a clap on the timeout cycle extends the sequence rather than closing it
            timer <= '0;
            if (count != CW'(MAX_CLAPS)) count <= count + 1'b1;
          end else if (timer == TW'(GAP_TIMEOUT - 1)) begin
            cmd_valid_o <= 1'b1;
            cmd_count_o <= count;
            if (count == CW'(2)) toggle_o <= ~toggle_o;
            count <= '0;
            timer <= '0;
`ifdef CLAP_COOLDOWN_EN
            state <= COOLDOWN;
`else
            state <= IDLE;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef CLAP_COOLDOWN_EN
        COOLDOWN: begin
          if (timer == TW'(COOLDOWN_CYCLES - 1)) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          count <= '0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clap_sequence_decoder.sv
// Scoreboard bench: stimulus pushes expected commands, a monitor pops and checks on cmd_valid_o.
// Runs the CLAP_COOLDOWN_EN scenarios when that macro is defined.
module tb_clap_sequence_decoder;

  localparam int unsigned GAP = 20;
  localparam int unsigned MAXC = 4;
  localparam int unsigned CD = 10;
  localparam int unsigned CW = $clog2(MAXC + 1);

  logic          M_CLK = 1'b0;
  logic          rst_i = 1'b1;
  logic          clap_pulse_i = 1'b0;
  logic          enable_i = 1'b1;
  logic          cmd_valid_o;
  logic [CW-1:0] cmd_count_o;
  logic          toggle_o;
  logic          busy_o;

  clap_sequence_decoder #(
    .GAP_TIMEOUT(GAP),
    .MAX_CLAPS(MAXC),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .M_CLK(M_CLK),
    .rst_i(rst_i),
    .clap_pulse_i(clap_pulse_i),
    .enable_i(enable_i),
    .cmd_valid_o(cmd_valid_o),
    .cmd_count_o(cmd_count_o),
    .toggle_o(toggle_o),
    .busy_o(busy_o)
  );

  always #5 M_CLK = ~M_CLK;

  typedef struct {
    int cnt;
    int tog;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every command the DUT presents must match the head of the scoreboard.
  always @(negedge M_CLK) begin
    if (rst_i === 1'b0 && cmd_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_cmd: got count %0d toggle %0d at cycle %0d, expected none",
                 cmd_count_o, toggle_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cmd_edge", cyc, e.at);
        chk("cmd_count", int'(cmd_count_o), e.cnt);
        chk("cmd_toggle", int'(toggle_o), e.tog);
      end
    end
  end

  task automatic tick();
    @(posedge M_CLK);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int e);
    while (cyc < e) tick();
  endtask

  // clap sampled by edge e
  task automatic clap_at(input int e);
    go_to(e - 1);
    clap_pulse_i = 1'b1;
    tick();
    clap_pulse_i = 1'b0;
  endtask

  task automatic push(input int cnt, input int tog, input int at);
    exp_t e;
    e.cnt = cnt; e.tog = tog; e.at = at;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, int'(cmd_valid_o), 0);
    chk({name, "_count"}, int'(cmd_count_o), 0);
    chk({name, "_toggle"}, int'(toggle_o), 0);
    chk({name, "_busy"}, int'(busy_o), 0);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    enable_i = 1'b1;
    clap_pulse_i = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_i = 1'b0;
    cyc = 0;
  endtask

  task automatic end_test(input string name);
    chk({name, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
`ifndef CLAP_COOLDOWN_EN
    // single clap
    reset_dut();
    push(1, 0, 25);
    clap_at(5);
    chk("t1_busy_e5", int'(busy_o), 1);
    go_to(24);
    chk("t1_busy_e24", int'(busy_o), 1);
    go_to(25);
    chk("t1_busy_e25", int'(busy_o), 0);
    go_to(30);
    chk("t1_count_hold", int'(cmd_count_o), 1);
    chk("t1_valid_low", int'(cmd_valid_o), 0);
    end_test("t1");

    // double clap toggles, repeat toggles back
    reset_dut();
    push(2, 1, 35);
    clap_at(5);
    clap_at(15);
    push(2, 0, 80);
    clap_at(50);
    clap_at(60);
    go_to(95);
    chk("t2_toggle_final", int'(toggle_o), 0);
    end_test("t2");

    // six claps saturate at MAX_CLAPS
    reset_dut();
    push(4, 0, 75);
    for (int i = 0; i < 6; i++) clap_at(5 + 10 * i);
    go_to(90);
    end_test("t3");

    // clap on the timeout edge extends the sequence
    reset_dut();
    push(2, 1, 45);
    clap_at(5);
    clap_at(25);
    go_to(60);
    end_test("t4");

    // enable drop aborts, claps ignored while disabled
    reset_dut();
    clap_at(5);
    go_to(11);
    chk("t5_busy_e11", int'(busy_o), 1);
    enable_i = 1'b0;
    tick();
    chk("t5_busy_e12", int'(busy_o), 0);
    clap_at(14);
    chk("t5_busy_e14", int'(busy_o), 0);
    go_to(40);
    enable_i = 1'b1;
    end_test("t5");

    // clap during the command cycle starts a new sequence
    reset_dut();
    push(1, 0, 25);
    push(1, 0, 46);
    clap_at(5);
    clap_at(26);
    chk("t6_busy_e26", int'(busy_o), 1);
    go_to(60);
    end_test("t6");
`else
    // cooldown ignores claps, then releases
    reset_dut();
    push(1, 0, 25);
    clap_at(5);
    clap_at(30);
    chk("c1_busy_e30", int'(busy_o), 1);
    go_to(34);
    chk("c1_busy_e34", int'(busy_o), 1);
    go_to(35);
    chk("c1_busy_e35", int'(busy_o), 0);
    push(1, 0, 60);
    clap_at(40);
    chk("c1_busy_e40", int'(busy_o), 1);
    go_to(65);
    chk("c1_busy_e65", int'(busy_o), 1);
    go_to(75);
    end_test("c1");

    // double clap under cooldown still toggles
    reset_dut();
    push(2, 1, 35);
    clap_at(5);
    clap_at(15);
    go_to(50);
    end_test("c2");
`endif

    // reset mid-sequence clears toggle and emits nothing
    reset_dut();
    push(2, 1, 35);
    clap_at(5);
    clap_at(15);
    go_to(40);
    chk("t7_toggle_set", int'(toggle_o), 1);
    chk("t7_count_set", int'(cmd_count_o), 2);
`ifdef CLAP_COOLDOWN_EN
    go_to(50);
`endif
    clap_at(cyc + 1);
    chk("t7_busy_open", int'(busy_o), 1);
    rst_i = 1'b1;
    tick();
    check_zero("t7_midreset");
    rst_i = 1'b0;
    go_to(cyc + 40);
    end_test("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
